turn_controller: RTL and testbench
==================================

# turn_controller

Sequencer for one 2048 turn. Accepts a single direction press, runs the shared datapath through move → sum → move using start/done handshakes, and places a new tile in a pseudo-random empty cell. It then samples the win/lose check and latches a terminal result. It sits above the movement, summation and check units and drives their direction and start strobes.

## Interface
Parameters:
- LFSR_SEED, 16'hACE1, reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11); must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk)
- dir_btn  in  4  raw direction level, one-hot {up,down,left,right}
- direction  out  4  registered direction, held stable from accept until return to IDLE
- move_start  out  1  one-cycle start strobe to movement unit
- move_done  in  1  movement complete
- sum_start  out  1  one-cycle start strobe to summation unit
- sum_done  in  1  summation complete
- board_changed  in  1  datapath flag: board differs from pre-turn board
- empty_mask  in  16  bit i=1 ⇔ cell i (row*4+col) is zero
- spawn_we  out  1  one-cycle tile write strobe
- spawn_idx  out  4  cell index written
- spawn_val  out  12  tile value written
- win, lose  in  1 each  check-unit results
- busy  out  1  high in every state except IDLE, WON, LOST
- wl  out  2  00 playing, 10 won, 01 lost, 11 turn in progress

## Operation
- States: IDLE, MOVE1, SUM, MOVE2, SPAWN, CHECK, WON, LOST.
- Press accept, in IDLE only:
  - dir_btn is exactly one-hot and the previous-cycle dir_btn was 4'b0000.
  - Multi-hot, held, or busy-time presses are dropped, not queued.
- On accept, direction ← dir_btn. Next state is MOVE1.
- MOVE1: move_start=1 on the entry cycle only; wait for move_done. Then SUM (sum_start on entry; wait sum_done). Then MOVE2 (move_start on entry; wait move_done). Then SPAWN.
- A done asserted during the start cycle is ignored. Done is accepted from the following cycle on.
- SPAWN, one cycle:
  - If board_changed=0 or empty_mask=0: no write.
  - Otherwise spawn_we=1. spawn_idx is the first set bit of empty_mask scanning upward from lfsr[3:0], wrapping 15→0.
  - spawn_val=12'd2.
  - Next state is CHECK.
- CHECK, one cycle: samples win/lose. win=1 → WON (win has priority). Else lose=1 → LOST. Else IDLE.
- WON and LOST are terminal until reset; all strobes are 0 there.
- LFSR advances every cycle outside reset, free-running, independent of state.
- direction is cleared to 0 on entry to IDLE.

## Timing
- Reset values: state IDLE, direction 0, move_start 0, sum_start 0, spawn_we 0, spawn_idx 0, spawn_val 0, busy 0, wl 00, lfsr LFSR_SEED, dir_btn history 0.
- Accept at cycle t → MOVE1 and move_start at t+1.
- Minimum turn with every done returned one cycle after its start: MOVE1 t+1..t+2, SUM t+3..t+4, MOVE2 t+5..t+6, SPAWN t+7, CHECK t+8, IDLE/WON/LOST at t+9.
- All outputs are registered or decoded from state only; no input→output combinational paths.
- busy rises at t+1 and falls on the cycle of exit to IDLE. wl=11 whenever busy=1.
- No timeout: a missing done holds the state indefinitely.
- Reset asserted mid-turn:
  - Next edge goes to IDLE with all strobes 0.
  - A spawn in progress is not written.
  - The LFSR reloads LFSR_SEED.

## Configuration
- SPAWN_FOUR_EN defined: spawn_val=12'd4 when lfsr[15:13]==3'b000 (1/8 odds), else 12'd2.
- SPAWN_FOUR_EN undefined: spawn_val is always 12'd2, and lfsr[15:13] is unused.

## Test plan
- Reset held low 3 cycles with dir_btn=4'b0100 → outputs at reset values. After release, press 4'b1000 → direction=4'b1000 and move_start one cycle later.
- Full turn, dones returned 1 cycle after each start, board_changed=1, empty_mask=16'h0001, win=lose=0 → sequence exactly as Timing. spawn_we at t+7 with idx 0, val 2. IDLE at t+9.
- empty_mask=16'h8000, lfsr[3:0] forced-known nonzero → spawn_idx=15 (wrap scan). board_changed=0 → no spawn_we.
- Press 4'b0011, then a press during busy, then a held button → all ignored. Only a 0000→one-hot transition starts a turn.
- CHECK with win=1, lose=1 → WON, wl=10. Further presses are ignored. After reset → IDLE, wl=00.
- SPAWN_FOUR_EN defined, 2000 spawns with empty board → roughly 1/8 of spawn_val are 4. Undefined → all 2.

Source files
------------

// File: rtl/turn_controller_if.sv
// Turn-level bus between the 2048 turn controller and the shared datapath.
//
// Handshake: the controller raises move_start / sum_start for exactly one
// cycle to launch a unit. The unit answers with its done flag; the controller
// ignores a done seen in the strobe cycle itself and accepts it on any later
// cycle. spawn_we is a one-cycle write strobe qualifying spawn_idx/spawn_val.
//
// Signals:
//   dir_btn        raw one-hot direction level {up,down,left,right}
//   direction      registered direction of the turn in progress
//   move_start/done, sum_start/done   unit start strobes and completions
//   board_changed  board differs from the pre-turn board
//   empty_mask     bit i set when cell i (row*4+col) is empty
//   spawn_we/idx/val  new-tile write port
//   win, lose      check-unit results
//   busy, wl       turn status: wl 00 playing, 10 won, 01 lost, 11 in turn
// Modports: master = turn controller, slave = datapath / board side.
interface turn_controller_if;
  logic [3:0]  dir_btn;
  logic [3:0]  direction;
  logic        move_start;
  logic        move_done;
  logic        sum_start;
  logic        sum_done;
  logic        board_changed;
  logic [15:0] empty_mask;
  logic        spawn_we;
  logic [3:0]  spawn_idx;
  logic [11:0] spawn_val;
  logic        win;
  logic        lose;
  logic        busy;
  logic [1:0]  wl;

  modport master (
    input  dir_btn, move_done, sum_done, board_changed, empty_mask, win, lose,
    output direction, move_start, sum_start, spawn_we, spawn_idx, spawn_val,
           busy, wl
  );

  modport slave (
    output dir_btn, move_done, sum_done, board_changed, empty_mask, win, lose,
    input  direction, move_start, sum_start, spawn_we, spawn_idx, spawn_val,
           busy, wl
  );
endinterface

// File: rtl/turn_controller.sv
// turn_controller: sequences one 2048 turn.
// A fresh one-hot press in IDLE runs move -> sum -> move on the datapath,
// spawns a tile in a pseudo-random empty cell, then samples win/lose and
// either returns to IDLE or latches WON / LOST until reset.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   tif        turn_controller_if.master (press input, unit strobes/dones,
//              spawn write port, busy / wl status)
//   dbg_state  current FSM state encoding, for observation only
// Parameters:
//   LFSR_SEED  reset value of the 16-bit Fibonacci LFSR, must be non-zero
// Build option:
//   SPAWN_FOUR_EN  when defined, a spawned tile is 4 with 1/8 odds
//                  (lfsr[15:13] == 0), otherwise it is always 2.
module turn_controller #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  turn_controller_if.master  tif,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE1 = 3'd1,
    S_SUM   = 3'd2,
    S_MOVE2 = 3'd3,
    S_SPAWN = 3'd4,
    S_CHECK = 3'd5,
    S_WON   = 3'd6,
    S_LOST  = 3'd7
  } state_t;

  state_t      state;
  logic [3:0]  direction_q;
  logic        move_start_q;
  logic        sum_start_q;
  logic        spawn_we_q;
  logic [3:0]  spawn_idx_q;
  logic [11:0] spawn_val_q;
  logic [3:0]  btn_prev;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        press_ok;
  logic [3:0]  scan_idx;
  logic        scan_hit;
  logic [3:0]  cand;
  logic [11:0] new_val;

  // Taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Only a 0000 -> one-hot edge counts as a press.
  assign press_ok = $onehot(tif.dir_btn) && (btn_prev == 4'b0000);

  // First empty cell at or above lfsr[3:0], wrapping 15 -> 0. Walking the
  // offsets downward lets the smallest offset overwrite the others.
  always_comb begin
    scan_idx = 4'd0;
    scan_hit = 1'b0;
    cand     = 4'd0;
    for (int j = 15; j >= 0; j--) begin
      cand = lfsr[3:0] + 4'(j);
      if (tif.empty_mask[cand]) begin
        scan_idx = cand;
        scan_hit = 1'b1;
      end
    end
  end

`ifdef SPAWN_FOUR_EN
  assign new_val = (lfsr[15:13] == 3'b000) ? 12'd4 : 12'd2;
`else
  assign new_val = 12'd2;
`endif

  // The start strobe register doubles as the "entry cycle" flag, so a done
  // that arrives together with its own start is never taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      direction_q  <= 4'd0;
      move_start_q <= 1'b0;
      sum_start_q  <= 1'b0;
      spawn_we_q   <= 1'b0;
      spawn_idx_q  <= 4'd0;
      spawn_val_q  <= 12'd0;
      btn_prev     <= 4'd0;
      lfsr         <= LFSR_SEED;
    end else begin
      btn_prev     <= tif.dir_btn;
      lfsr         <= {lfsr[14:0], lfsr_fb};
      move_start_q <= 1'b0;
      sum_start_q  <= 1'b0;
      spawn_we_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press_ok) begin
            direction_q  <= tif.dir_btn;
            move_start_q <= 1'b1;
            state        <= S_MOVE1;
          end
        end
        S_MOVE1: begin
          if (!move_start_q && tif.move_done) begin
            sum_start_q <= 1'b1;
            state       <= S_SUM;
          end
        end
        S_SUM: begin
          if (!sum_start_q && tif.sum_done) begin
            move_start_q <= 1'b1;
            state        <= S_MOVE2;
          end
        end
        S_MOVE2: begin
          // The spawn write is registered on the way into SPAWN so that
          // spawn_we is high for exactly the SPAWN cycle.
          if (!move_start_q && tif.move_done) begin
            state <= S_SPAWN;
            if (tif.board_changed && scan_hit) begin
              spawn_we_q  <= 1'b1;
              spawn_idx_q <= scan_idx;
              spawn_val_q <= new_val;
            end
          end
        end
        S_SPAWN: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (tif.win) begin
            state <= S_WON;
          end else if (tif.lose) begin
            state <= S_LOST;
          end else begin
            state       <= S_IDLE;
            direction_q <= 4'd0;
          end
        end
        S_WON, S_LOST: begin
          state <= state;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign tif.direction  = direction_q;
  assign tif.move_start = move_start_q;
  assign tif.sum_start  = sum_start_q;
  assign tif.spawn_we   = spawn_we_q;
  assign tif.spawn_idx  = spawn_idx_q;
  assign tif.spawn_val  = spawn_val_q;
  assign tif.busy       = (state != S_IDLE) && (state != S_WON) && (state != S_LOST);

  always_comb begin
    case (state)
      S_IDLE:  tif.wl = 2'b00;
      S_WON:   tif.wl = 2'b10;
      S_LOST:  tif.wl = 2'b01;
      default: tif.wl = 2'b11;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_turn_controller.sv
module tb_turn_controller;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  turn_controller_if tif();

  turn_controller #(.LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .tif       (tif),
    .dbg_state (dbg_state)
  );

  // Expected outputs for one cycle.
  typedef struct {
    logic        busy;
    logic [1:0]  wl;
    logic [3:0]  dir;
    logic        ms;
    logic        ss;
    logic        sw;
    logic        chk_sp;
    logic [3:0]  si;
    logic [11:0] sv;
  } exp_t;

  typedef struct {
    int          c;
    int          sel;
    logic [15:0] v;
    string       nm;
  } pin_t;

  exp_t exp_a[int];
  exp_t rest;
  exp_t cur;
  pin_t pin_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_sp  = 0;
  int n_four = 0;

  // LFSR reference, advanced lazily up to the cycle asked for.
  int          lf_k = 0;
  logic [15:0] lf_v = SEED;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(logic busy, logic [1:0] wl, logic [3:0] dir, logic chk_sp);
    exp_t r;
    r.busy = busy; r.wl = wl; r.dir = dir;
    r.ms = 1'b0; r.ss = 1'b0; r.sw = 1'b0;
    r.chk_sp = chk_sp; r.si = 4'd0; r.sv = 12'd0;
    return r;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  function automatic logic [15:0] out_of(int sel);
    case (sel)
      0: return 16'(tif.busy);
      1: return 16'(tif.wl);
      2: return 16'(tif.direction);
      3: return 16'(tif.move_start);
      4: return 16'(tif.sum_start);
      5: return 16'(tif.spawn_we);
      6: return 16'(tif.spawn_idx);
      default: return 16'(tif.spawn_val);
    endcase
  endfunction

  task automatic add_pin(input int c, input int sel, input logic [15:0] v, input string nm);
    pin_t p;
    p.c = c; p.sel = sel; p.v = v; p.nm = nm;
    pin_q.push_back(p);
  endtask

  task automatic lfsr_at(input int k, output logic [15:0] v);
    while (lf_k < k) begin
      lf_v = {lf_v[14:0], lf_v[15] ^ lf_v[13] ^ lf_v[12] ^ lf_v[10]};
      lf_k++;
    end
    v = lf_v;
  endtask

  // Compare process: every cycle that has an expectation is checked.
  always @(negedge clk) begin
    if (exp_a.exists(cyc)) begin
      cur = exp_a[cyc];
      check("busy", 16'(tif.busy), 16'(cur.busy));
      check("wl", 16'(tif.wl), 16'(cur.wl));
      check("direction", 16'(tif.direction), 16'(cur.dir));
      check("move_start", 16'(tif.move_start), 16'(cur.ms));
      check("sum_start", 16'(tif.sum_start), 16'(cur.ss));
      check("spawn_we", 16'(tif.spawn_we), 16'(cur.sw));
      if (cur.chk_sp) begin
        check("spawn_idx", 16'(tif.spawn_idx), 16'(cur.si));
        check("spawn_val", 16'(tif.spawn_val), 16'(cur.sv));
      end
      exp_a.delete(cyc);
    end
    for (int i = pin_q.size() - 1; i >= 0; i--) begin
      if (pin_q[i].c == cyc) begin
        check(pin_q[i].nm, out_of(pin_q[i].sel), pin_q[i].v);
        pin_q.delete(i);
      end
    end
    if (tif.spawn_we === 1'b1) begin
      n_sp++;
      if (tif.spawn_val == 12'd4) n_four++;
    end
  end

  // Advance one cycle; the next cycle defaults to the resting expectation.
  task automatic tick();
    if (!exp_a.exists(cyc + 1)) exp_a[cyc + 1] = rest;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tif.move_done = 1'b0; tif.sum_done = 1'b0;
    tif.win = 1'b0; tif.lose = 1'b0;
  endtask

  task automatic apply_reset(input int n, input logic [3:0] btn);
    int ks[$];
    foreach (exp_a[k]) if (k > cyc) ks.push_back(k);
    foreach (ks[i]) exp_a.delete(ks[i]);
    rest = mk(1'b0, 2'b00, 4'd0, 1'b1);
    rst = 1'b0;
    tif.dir_btn = btn;
    clear_inputs();
    repeat (n) tick();
    rst = 1'b1;
    tif.dir_btn = 4'd0;
    rest = mk(1'b0, 2'b00, 4'd0, 1'b0);
    lf_k = cyc;
    lf_v = SEED;
  endtask

  task automatic idle_btn(input logic [3:0] b);
    tif.dir_btn = b;
    tick();
  endtask

  // One turn. Press at cycle t; each done comes dN cycles after its start.
  // res: 0 idle, 1 won, 2 lost, 3 aborted by reset.
  task automatic do_turn(input logic [3:0] d, input int d1, input int d2, input int d3,
                         input logic ch, input logic [15:0] mask,
                         input logic w, input logic l, input logic early,
                         input logic abort_en, output int res);
    int t, s, m2, p, e, ab, si;
    logic hit;
    logic [15:0] lv;
    logic [11:0] val;
    exp_t r, outcome;
    t  = cyc;
    s  = t + 2 + d1;
    m2 = s + d2 + 1;
    p  = m2 + d3 + 1;
    e  = p + 2;
    lfsr_at(p - 1, lv);
    hit = 1'b0;
    si  = 0;
    if (ch) begin
      for (int j = 0; j < 16; j++) begin
        if (!hit && mask[(lv[3:0] + j) % 16]) begin
          hit = 1'b1;
          si  = (lv[3:0] + j) % 16;
        end
      end
    end
`ifdef SPAWN_FOUR_EN
    val = (lv[15:13] == 3'b000) ? 12'd4 : 12'd2;
`else
    val = 12'd2;
`endif
    for (int c = t + 1; c <= p + 1; c++) begin
      r = mk(1'b1, 2'b11, d, 1'b0);
      r.ms = (c == t + 1) || (c == m2);
      r.ss = (c == s);
      r.sw = (c == p) && hit;
      r.chk_sp = (c == p) && hit;
      r.si = 4'(si);
      r.sv = val;
      exp_a[c] = r;
    end
    if (w)      begin outcome = mk(1'b0, 2'b10, d, 1'b0); res = 1; end
    else if (l) begin outcome = mk(1'b0, 2'b01, d, 1'b0); res = 2; end
    else        begin outcome = mk(1'b0, 2'b00, 4'd0, 1'b0); res = 0; end
    ab = 0;
    if (abort_en) ab = ($urandom_range(0, 1) == 0) ? (p - 1 - t) : $urandom_range(1, p - t);
    tif.board_changed = ch;
    tif.empty_mask = mask;
    for (int c = t; c < e; c++) begin
      if (c == t) tif.dir_btn = d;
      else if (c >= p + 1) tif.dir_btn = 4'd0;
      else tif.dir_btn = 4'($urandom_range(0, 15));
      tif.move_done = (c == t + d1 + 1) || (c == m2 + d3) || (early && (c == t + 1 || c == m2));
      tif.sum_done  = (c == s + d2) || (early && c == s);
      if (c == p + 1) begin
        tif.win = w; tif.lose = l;
      end else begin
        tif.win = 1'($urandom_range(0, 1)); tif.lose = 1'($urandom_range(0, 1));
      end
      if (abort_en && c == t + ab) begin
        apply_reset(2, 4'd0);
        res = 3;
        return;
      end
      if (c == e - 1) rest = outcome;
      tick();
    end
    clear_inputs();
    tif.dir_btn = 4'd0;
  endtask

  initial begin
    int t, res, d1, d2, d3, rr;
    logic [3:0] d;
    logic [15:0] mask;
    logic ch, w, l;

    tif.dir_btn = 4'd0;
    tif.board_changed = 1'b0;
    tif.empty_mask = 16'd0;
    clear_inputs();

    // Reset with a button held: outputs at reset values.
    apply_reset(3, 4'b0100);
    add_pin(cyc, 0, 16'h0, "rst_busy");
    add_pin(cyc, 1, 16'h0, "rst_wl");
    add_pin(cyc, 2, 16'h0, "rst_dir");
    add_pin(cyc, 6, 16'h0, "rst_idx");

    // Minimum-latency turn right after reset.
    t = cyc;
    add_pin(t + 1, 2, 16'h8, "min_dir");
    add_pin(t + 1, 3, 16'h1, "min_move_start");
    add_pin(t + 3, 4, 16'h1, "min_sum_start");
    add_pin(t + 5, 3, 16'h1, "min_move2_start");
    add_pin(t + 7, 5, 16'h1, "min_spawn_we");
    add_pin(t + 7, 6, 16'h0, "min_spawn_idx");
`ifndef SPAWN_FOUR_EN
    add_pin(t + 7, 7, 16'h2, "min_spawn_val");
`endif
    add_pin(t + 8, 1, 16'h3, "min_wl_check");
    add_pin(t + 9, 0, 16'h0, "min_busy_end");
    add_pin(t + 9, 1, 16'h0, "min_wl_end");
    do_turn(4'b1000, 1, 1, 1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, res);

    // Wrap-around scan: only cell 15 empty.
    t = cyc;
    add_pin(t + 7, 5, 16'h1, "wrap_we");
    add_pin(t + 7, 6, 16'hF, "wrap_idx");
    do_turn(4'b0001, 1, 1, 1, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, res);

    // Unchanged board: no spawn.
    t = cyc;
    add_pin(t + 7, 5, 16'h0, "nochange_we");
    do_turn(4'b0100, 1, 1, 1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, res);

    // Multi-hot, then held one-hot: ignored.
    idle_btn(4'b0011);
    idle_btn(4'b0010);
    idle_btn(4'b0010);
    idle_btn(4'b0010);
    add_pin(cyc, 0, 16'h0, "held_busy");
    idle_btn(4'b0000);

    // Randomized turns with varying latency, early dones and resets.
    for (int n = 0; n < 150; n++) begin
      d  = 4'b0001 << $urandom_range(0, 3);
      d1 = $urandom_range(1, 4);
      d2 = $urandom_range(1, 4);
      d3 = $urandom_range(1, 4);
      ch = ($urandom_range(0, 3) != 0);
      mask = 16'($urandom);
      if ($urandom_range(0, 4) == 0) mask = 16'd0;
      if ($urandom_range(0, 4) == 0) mask = 16'h0001 << $urandom_range(0, 15);
      rr = $urandom_range(0, 15);
      w = (rr == 0) || (rr == 2);
      l = (rr == 1) || (rr == 2);
      do_turn(d, d1, d2, d3, ch, mask, w, l, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0), res);
      if (res == 1 || res == 2) begin
        idle_btn(4'b0000);
        idle_btn(4'b0001 << $urandom_range(0, 3));
        idle_btn(4'b0000);
        apply_reset(2, 4'd0);
      end
      if ($urandom_range(0, 3) == 0) idle_btn(4'b0000);
    end

    // win and lose together: win wins, and the game stays won.
    t = cyc;
    add_pin(t + 10, 1, 16'h2, "won_wl");
    add_pin(t + 10, 0, 16'h0, "won_busy");
    do_turn(4'b0010, 1, 2, 1, 1'b1, 16'hF0F0, 1'b1, 1'b1, 1'b0, 1'b0, res);
    idle_btn(4'b0000);
    idle_btn(4'b0100);
    idle_btn(4'b0000);
    idle_btn(4'b1000);
    add_pin(cyc, 1, 16'h2, "won_after_press");
    idle_btn(4'b0000);
    apply_reset(1, 4'd0);
    add_pin(cyc, 1, 16'h0, "reset_wl");

    // Many spawns on an empty board for the tile-value distribution.
    n_sp = 0;
    n_four = 0;
    for (int n = 0; n < 2000; n++) begin
      do_turn(4'b0001 << (n % 4), 1, 1, 1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, res);
    end
    tick();
    tick();
    check("spawn_count", 16'(n_sp), 16'd2000);
`ifdef SPAWN_FOUR_EN
    check("four_ratio_ok", 16'((n_four >= 2000 / 16) && (n_four <= 2000 * 3 / 16)), 16'd1);
`else
    check("four_count", 16'(n_four), 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
